// File: rtl/mips_branch_predictor.sv
// Direct-mapped dynamic branch predictor: saturating-counter table plus BTB,
// combinational fetch lookup, M-stage training, registered mispredict/redirect and stats.
module mips_branch_predictor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [XLEN-1:0]   f_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned CTR_MAX = (1 << CTR_W) - 1;
  localparam int unsigned CTR_WT  = 1 << (CTR_W - 1);
  localparam int unsigned CTR_WNT = CTR_WT - 1;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit, wrong;

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads registered table state, so a same-cycle update is seen next cycle.
  always_comb begin
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = f_hit && ctr_q[f_idx][CTR_W-1];
    pred_target = pred_taken ? target_q[f_idx] : f_pc + XLEN'(4);
  end

  always_comb begin
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    wrong = upd_valid && ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_W'(CTR_WNT);
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          target_q[u_idx] <= upd_target;
          if (ctr_q[u_idx] != CTR_W'(CTR_MAX))
            ctr_q[u_idx] <= ctr_q[u_idx] + CTR_W'(1);
        end else if (ctr_q[u_idx] != '0) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= CTR_W'(CTR_WT);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      mispredict <= wrong;
      if (upd_valid) begin
        redirect_pc <= upd_taken ? upd_target : upd_pc + XLEN'(4);
        if (stat_branches != '1)
          stat_branches <= stat_branches + STAT_W'(1);
        if (wrong && (stat_mispredicts != '1))
          stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Directed self-checking bench for mips_branch_predictor (ENTRIES=16, STAT_W=4).
module tb_mips_branch_predictor;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [31:0] f_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  stat_branches;
  logic [3:0]  stat_mispredicts;

  int checks = 0;
  int errors = 0;

  mips_branch_predictor #(
    .XLEN(32), .ENTRIES(16), .TAG_W(8), .CTR_W(2), .STAT_W(4)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    upd_valid = 1'b0;
    step();
    step();
    RSTn = 1'b1;
  endtask

  // One-cycle update pulse; on return the registered outputs reflect it.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg;
    upd_pred_taken = ptk; upd_pred_target = ptg;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    f_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL reset_pred_target: got %h expected 00000044", pred_target); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b expected 0", mispredict); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %h expected 00000000", redirect_pc); end
    checks++; if (stat_branches !== 4'd0 || stat_mispredicts !== 4'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts); end
  endtask

  task automatic test_train_taken();
    upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL train_mispredict: got %b expected 1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL train_redirect: got %h expected 00000080", redirect_pc); end
    f_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_pred_taken: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL train_pred_target: got %h expected 00000080", pred_target); end
    checks++; if (stat_branches !== 4'd1 || stat_mispredicts !== 4'd1) begin errors++; $display("FAIL train_stats: got %0d/%0d expected 1/1", stat_branches, stat_mispredicts); end
    step();
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL train_pulse_end: got %b expected 0", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL train_redirect_hold: got %h expected 00000080", redirect_pc); end
  endtask

  task automatic test_hysteresis();
    // ctr starts at 2 from the allocation above; two correct taken -> 3 (saturated)
    upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL hyst_correct_taken: got %b expected 0", mispredict); end
    upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL hyst_nt_mispredict: got %b expected 1", mispredict); end
    checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL hyst_nt_redirect: got %h expected 00000044", redirect_pc); end
    f_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL hyst_one_nt: got %b expected 1", pred_taken); end
    upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin errors++; $display("FAIL hyst_two_nt: got %b/%h expected 0/00000044", pred_taken, pred_target); end
    // drive to 0 and past it; one taken must then leave it not-taken (ctr 1)
    upd(32'h40, 1'b0, 32'h80, 1'b0, 32'h44);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL hyst_correct_nt: got %b expected 0", mispredict); end
    upd(32'h40, 1'b0, 32'h80, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL hyst_floor: got %b expected 0", pred_taken); end
    upd(32'h40, 1'b1, 32'h90, 1'b0, 32'h44);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin errors++; $display("FAIL hyst_retrain: got %b/%h expected 1/00000090", pred_taken, pred_target); end
    // right direction, wrong target
    upd(32'h40, 1'b1, 32'h90, 1'b1, 32'hA0);
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h90) begin errors++; $display("FAIL hyst_target_wrong: got %b/%h expected 1/00000090", mispredict, redirect_pc); end
  endtask

  task automatic test_alias();
    do_reset();
    upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    upd(32'h440, 1'b1, 32'h200, 1'b0, 32'h444);
    f_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin errors++; $display("FAIL alias_evicted: got %b/%h expected 0/00000044", pred_taken, pred_target); end
    // not-taken miss at same index must not allocate
    upd(32'h80, 1'b0, 32'h300, 1'b0, 32'h84);
    checks++; if (redirect_pc !== 32'h84) begin errors++; $display("FAIL alias_nt_redirect: got %h expected 00000084", redirect_pc); end
    f_pc = 32'h440; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin errors++; $display("FAIL alias_hit: got %b/%h expected 1/00000200", pred_taken, pred_target); end
    upd(32'h440, 1'b0, 32'h200, 1'b1, 32'h200);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_ctr2: got %b expected 0", pred_taken); end
    checks++; if (stat_branches !== 4'd4 || stat_mispredicts !== 4'd3) begin errors++; $display("FAIL alias_stats: got %0d/%0d expected 4/3", stat_branches, stat_mispredicts); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    f_pc = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h80;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin errors++; $display("FAIL same_cycle_old: got %b/%h expected 0/00000044", pred_taken, pred_target); end
    step();
    upd_valid = 1'b0; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin errors++; $display("FAIL same_cycle_new: got %b/%h expected 1/00000080", pred_taken, pred_target); end
    // update during reset is ignored
    RSTn = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h300;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
    step();
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rst_upd_mispredict: got %b expected 0", mispredict); end
    checks++; if (stat_branches !== 4'd0 || stat_mispredicts !== 4'd0) begin errors++; $display("FAIL rst_upd_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_upd_table: got %b expected 0", pred_taken); end
    RSTn = 1'b1; upd_valid = 1'b0;
    step();
    checks++; if (mispredict !== 1'b0 || pred_taken !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_upd_after: got %b/%b/%h expected 0/0/00000000", mispredict, pred_taken, redirect_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    upd_valid = 1'b1; upd_taken = 1'b1; upd_pred_taken = 1'b0;
    for (int i = 0; i < 20; i++) begin
      upd_pc = 32'h1000 + 32'(i) * 4;
      upd_target = 32'h2000 + 32'(i) * 16;
      upd_pred_target = upd_pc + 4;
      step();
      checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h2000 + 32'(i) * 16) begin errors++; $display("FAIL b2b_pulse[%0d]: got %b/%h expected 1/%h", i, mispredict, redirect_pc, 32'h2000 + 32'(i) * 16); end
      if (i == 14) begin
        checks++; if (stat_branches !== 4'd15 || stat_mispredicts !== 4'd15) begin errors++; $display("FAIL b2b_stats15: got %0d/%0d expected 15/15", stat_branches, stat_mispredicts); end
      end
    end
    upd_valid = 1'b0;
    step();
    checks++; if (stat_branches !== 4'd15 || stat_mispredicts !== 4'd15) begin errors++; $display("FAIL b2b_saturate: got %0d/%0d expected 15/15", stat_branches, stat_mispredicts); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", mispredict); end
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_branch_predictor.md
Name: mips_branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS32 pipeline. It replaces the fixed "stall until resolved in M" branch handling.
- Fetch looks up a direct-mapped table of saturating counters plus a branch target buffer (BTB) and gets a same-cycle taken/target prediction.
- The M stage reports each resolved beq/bne. The block trains the table, flags mispredictions one cycle later with the correct redirect PC, and keeps performance counters.

Parameters:
- XLEN, 32, PC/target width in bits.
- ENTRIES, 16, table depth; power of two, >=2; IDX_W = log2(ENTRIES).
- TAG_W, 8, BTB tag width; tag = pc[IDX_W+TAG_W+1 : IDX_W+2].
- CTR_W, 2, saturating counter width, 1..4.
- STAT_W, 16, width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  synchronous, active-low reset.
- f_pc  in  XLEN  fetch-stage PC to predict.
- pred_taken  out  1  combinational; predict taken for f_pc.
- pred_target  out  XLEN  combinational; predicted target, valid when pred_taken=1, else f_pc+4.
- upd_valid  in  1  M stage resolved a conditional branch this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual branch target (PCBranch_M).
- upd_pred_taken  in  1  prediction that was made for this branch, carried down the pipe.
- upd_pred_target  in  XLEN  predicted target carried down the pipe.
- mispredict  out  1  registered; high one cycle after a wrong update.
- redirect_pc  out  XLEN  registered; correct next PC, valid when mispredict=1.
- stat_branches  out  STAT_W  count of upd_valid events.
- stat_mispredicts  out  STAT_W  count of mispredicts.

Behaviour:
- Index = pc[IDX_W+1:2]. Each entry holds valid, tag[TAG_W], target[XLEN] and ctr[CTR_W].
- Reset (RSTn=0 at posedge):
  - all valid=0, ctr=WNT (2^(CTR_W-1)-1).
  - mispredict=0, redirect_pc=0, both stats=0.
  - An upd_valid in a reset cycle is ignored entirely.
- Lookup is combinational, zero latency.
  - hit = valid && tag match.
  - pred_taken = hit && ctr[CTR_W-1].
  - pred_target = pred_taken ? target : f_pc+4, computed modulo 2^XLEN.
- Update, on posedge with RSTn=1 and upd_valid=1, at the entry selected by upd_pc:
  - Hit: ctr saturating +1 if taken, -1 if not taken, clamped to 0 and 2^CTR_W-1. If taken, target<=upd_target.
  - Miss (invalid or tag mismatch), taken: allocate/replace. valid<=1, tag<=upd tag, target<=upd_target, ctr<=WT (2^(CTR_W-1)).
  - Miss, not taken: table unchanged; no allocation.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (read-before-write). The new state is visible from the next cycle.
- Mispredict detection:
  - wrong = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_pred_target != upd_target)).
  - Next posedge: mispredict<=wrong; redirect_pc<=upd_taken ? upd_target : upd_pc+4.
  - mispredict is a one-cycle pulse per wrong update. Back-to-back wrong updates give back-to-back pulses.
  - When upd_valid=0, mispredict<=0 and redirect_pc holds its value.
- Stats: stat_branches +1 per accepted update; stat_mispredicts +1 per wrong update. Both saturate at 2^STAT_W-1 and never wrap.
- Pipeline contract, owned by the core:
  - On mispredict it flushes F/D/E and loads redirect_pc.
  - upd_* come only from a valid, unflushed branch in M.
  - The predictor does not track in-flight branches.
- Only beq/bne are handled. j/jr are never reported.

Test Plan:
- Cold table, reset then f_pc=0x40 -> pred_taken=0, pred_target=0x44.
- Train taken at upd_pc=0x40, upd_target=0x80, pred_taken=0, pred_target=0x44 -> next cycle mispredict=1, redirect_pc=0x80. Lookup 0x40 then gives pred_taken=1, pred_target=0x80, ctr=2.
- Hysteresis (CTR_W=2): taken x3 -> ctr=3 saturated. One not-taken -> still predicts taken. Second not-taken -> predicts not taken.
- Alias (ENTRIES=16): pc 0x40 trained taken, then taken update at 0x440 (same index, different tag) -> 0x40 lookup misses (pred_taken=0); 0x440 hits with ctr=2.
- Same-cycle update/lookup at 0x40 -> old prediction that cycle, new one the next. Assert RSTn=0 with upd_valid=1 -> table cleared, no mispredict pulse, stats 0.
- STAT_W=4: 20 wrong updates -> stat_branches=15, stat_mispredicts=15, no wrap.
